// File: rtl/vga_pkg.sv
// Shared video-memory definitions: frame size, pixel width, {x,y} address packing, arbiter states.
package vga_pkg;

  localparam int H_PIX_DEF = 640;
  localparam int V_PIX_DEF = 480;
  localparam int PIX_W     = 12;
  localparam int XW        = 10;
  localparam int YW        = 9;
  localparam int AW        = XW + YW;

  typedef logic [AW-1:0] vaddr_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  function automatic vaddr_t pack_xy(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; the head is presented combinationally, so a pop takes effect the same cycle.
// Pushes while full and pops while empty are ignored; count, full and empty come from registered state.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Video memory arbiter: display reads own active video; blanking slots go to the clear engine, then host FIFO.
// Port mux is combinational (zero added latency); host is stalled only by a full FIFO.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int H_PIX      = H_PIX_DEF,
  parameter int V_PIX      = V_PIX_DEF,
  parameter int DW         = PIX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_active,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int FW = AW + DW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIX - 1);

  arb_state_t    r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [DW-1:0] r_color;

  logic          w_slot;
  logic          w_clr_wr;
  logic          w_fifo_wr;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [FW-1:0] w_head;

  assign w_slot     = !disp_active;
  assign w_clr_wr   = w_slot && (r_state == CLEAR);
  // The FIFO is held while clearing so queued host pixels land on top of the fill.
  assign w_fifo_wr  = w_slot && (r_state == IDLE) && !w_empty;
  assign host_ready = (w_count < CW'(FIFO_DEPTH));
  assign w_push     = host_valid && !w_full;
  assign clr_busy   = (r_state == CLEAR);
  assign disp_data  = mem_rdata;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_host_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat ({host_addr, host_data}),
    .i_pop      (w_fifo_wr),
    .o_pop_dat  (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_comb begin
    mem_addr  = disp_addr;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (w_clr_wr) begin
      mem_addr  = pack_xy(r_x, r_y);
      mem_wdata = r_color;
      mem_we    = 1'b1;
    end else if (w_fifo_wr) begin
      mem_addr  = w_head[FW-1:DW];
      mem_wdata = w_head[DW-1:0];
      mem_we    = 1'b1;
    end
  end

  // Sweep is column-major: y runs fastest, x steps when y wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_state <= CLEAR;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= clr_color;
          end
        end
        CLEAR: begin
          if (w_clr_wr) begin
            if (r_y == Y_LAST) begin
              r_y <= '0;
              if (r_x == X_LAST) begin
                r_x     <= '0;
                r_state <= IDLE;
              end else begin
                r_x <= r_x + XW'(1);
              end
            end else begin
              r_y <= r_y + YW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter with a small 4x3 frame and a queue-based reference model.
module tb_vga_vram_arbiter;

  localparam int H     = 4;
  localparam int V     = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [18:0] a;
    logic [11:0] d;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [11:0] v;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_active = 1'b0;
  logic [18:0] disp_addr = '0;
  logic [11:0] disp_data;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [18:0] host_addr = '0;
  logic [11:0] host_data = '0;
  logic        clr_start = 1'b0;
  logic [11:0] clr_color = '0;
  logic        clr_busy;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_we;
  logic [11:0] mem_rdata = '0;

  vga_vram_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .H_PIX      (H),
    .V_PIX      (V),
    .DW         (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_active (disp_active),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .clr_start   (clr_start),
    .clr_color   (clr_color),
    .clr_busy    (clr_busy),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_wr = 0;
  int exp_wr_cyc = -1;

  wr_t hq[$];
  wr_t expq[$];
  rd_t rdq[$];
  logic [11:0] ref_mem [logic [18:0]];
  logic [11:0] vram [logic [18:0]];
  bit          m_clr = 1'b0;
  int          m_k = 0;
  logic [11:0] m_color = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    mem_rdata <= vram.exists(mem_addr) ? vram[mem_addr] : 12'h000;
    if (mem_we === 1'b1) vram[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 12'h000;
  endfunction

  function automatic logic [11:0] vram_rd(input logic [18:0] a);
    return vram.exists(a) ? vram[a] : 12'h000;
  endfunction

  function automatic logic [18:0] xy(input int x, input int y);
    return {10'(x), 9'(y)};
  endfunction

  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    chk("mem_we", 32'(mem_we), 32'(exp_wr_cyc == cyc));
    if (mem_we === 1'b1 && expq.size() != 0) begin
      w = expq.pop_front();
      n_wr++;
      chk("wr_addr", 32'(mem_addr), 32'(w.a));
      chk("wr_data", 32'(mem_wdata), 32'(w.d));
      ref_mem[w.a] = w.d;
    end
    if (rdq.size() != 0 && rdq[0].cyc == cyc) begin
      r = rdq.pop_front();
      chk("disp_data", 32'(disp_data), 32'(r.v));
    end
  end

  // One pixel clock: drive inputs, advance the reference model, then cross the edge.
  task automatic step(input bit da, input logic [18:0] daddr, input bit hv,
                      input logic [18:0] ha, input logic [11:0] hd,
                      input bit cs, input logic [11:0] cc);
    bit  rdy_exp;
    bit  busy0;
    wr_t w;
    disp_active = da; disp_addr = daddr;
    host_valid = hv; host_addr = ha; host_data = hd;
    clr_start = cs; clr_color = cc;
    rdy_exp = (hq.size() < DEPTH);
    busy0   = m_clr;
    chk("host_ready", 32'(host_ready), 32'(rdy_exp));
    chk("clr_busy", 32'(clr_busy), 32'(busy0));
    if (da) begin
      rdq.push_back('{cyc + 1, ref_rd(daddr)});
    end else if (m_clr) begin
      w.a = xy(m_k / V, m_k % V);
      w.d = m_color;
      expq.push_back(w);
      exp_wr_cyc = cyc;
      m_k++;
      if (m_k == H * V) m_clr = 1'b0;
    end else if (hq.size() != 0) begin
      expq.push_back(hq.pop_front());
      exp_wr_cyc = cyc;
    end
    if (cs && !busy0) begin
      m_clr = 1'b1; m_k = 0; m_color = cc;
    end
    if (hv && rdy_exp) hq.push_back('{ha, hd});
    @(posedge clk); #1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_clr || hq.size() != 0) && guard < 200) begin
      blank(1);
      guard++;
    end
    chk("drain_bound", 32'(m_clr || hq.size() != 0), 32'd0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_host_ready", 32'(host_ready), 32'd1);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    hq.delete(); expq.delete(); rdq.delete();
    m_clr = 1'b0; m_k = 0; exp_wr_cyc = -1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int wr_before;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_host_ready", 32'(host_ready), 32'd1);
    chk("reset_clr_busy", 32'(clr_busy), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;

    // Seed 0x1234, then queue four writes behind active video while reading it back.
    step(1'b0, '0, 1'b1, 19'h1234, 12'hABC, 1'b0, '0);
    blank(2);
    for (int i = 0; i < 4; i++)
      step(1'b1, 19'h1234, 1'b1, xy(2, i % 3) + 19'(i * 16), 12'h100 + 12'(i), 1'b0, '0);
    chk("prio_no_write", 32'(n_wr), 32'd1);
    step(1'b1, 19'h1234, 1'b0, '0, '0, 1'b0, '0);
    blank(5);
    chk("prio_drained", 32'(n_wr), 32'd5);

    // Fifth push during active video must bounce off a full FIFO.
    for (int i = 0; i < 5; i++)
      step(1'b1, 19'h0005, 1'b1, xy(3, i % 3), 12'h200 + 12'(i), 1'b0, '0);
    chk("full_ready_low", 32'(host_ready), 32'd0);
    blank(1);
    chk("ready_after_pop", 32'(host_ready), 32'd1);
    drain();

    // Full clear with a host write queued mid-clear.
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 12'hF00);
    chk("clr_busy_rise", 32'(clr_busy), 32'd1);
    for (int i = 0; i < 10; i++)
      step(i % 3 == 1, xy(i % 4, i % 3), i == 2, xy(1, 1), 12'h0F0, 1'b0, '0);
    drain();
    blank(2);
    chk("clr_busy_fall", 32'(clr_busy), 32'd0);
    chk("host_over_clear", 32'(vram_rd(xy(1, 1))), 32'h0F0);
    chk("clear_last_px", 32'(vram_rd(xy(3, 2))), 32'hF00);

    // Abort a clear after five writes, then restart it.
    step(1'b1, '0, 1'b0, '0, '0, 1'b1, 12'h00F);
    wr_before = n_wr;
    blank(5);
    chk("five_clear_writes", 32'(n_wr - wr_before), 32'd5);
    async_reset();
    wr_before = n_wr;
    blank(6);
    chk("no_write_after_rst", 32'(n_wr - wr_before), 32'd0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 12'h0AA);
    drain();
    chk("restart_first_px", 32'(vram_rd(xy(0, 0))), 32'h0AA);

    // Randomised traffic over a small address window.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, xy($urandom_range(0, 3), $urandom_range(0, 2)),
           $urandom_range(0, 1) == 1, xy($urandom_range(0, 3), $urandom_range(0, 2)),
           12'($urandom), $urandom_range(0, 199) == 0, 12'($urandom));
    drain();
    blank(2);
    chk("expq_empty", 32'(expq.size()), 32'd0);
    chk("rdq_empty", 32'(rdq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Single-clock arbiter and sequencer for the 640x480 12-bit video memory shared by the VGA scan-out path and a host write port. Display reads always win during active video. Host writes are buffered in a small FIFO and drained during blanking. A built-in clear engine fills the whole frame with one colour on command. It sits between `vga_ctrl` (address source, pixel sink) and the single-port `vd_mem`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: host write FIFO entries (power of two, ≥2)
- `H_PIX`, 640: horizontal pixels swept by the clear engine
- `V_PIX`, 480: vertical lines swept by the clear engine
- `DW`, 12: pixel width, {R[3:0],G[3:0],B[3:0]}

Ports:
- `clk` in 1: pixel clock (25 MHz pclk)
- `rst` in 1: asynchronous, active-high reset
- `disp_active` in 1: display is in the visible area and needs a read this cycle
- `disp_addr` in 19: {h_addr[9:0], v_addr[8:0]} from the display timing block
- `disp_data` out DW: pixel to the display, equal to `mem_rdata`
- `host_valid` in 1: host offers a write
- `host_ready` out 1: FIFO can accept a write
- `host_addr` in 19: write address, same {x,y} packing
- `host_data` in DW: write pixel
- `clr_start` in 1: single-cycle pulse that starts a full-frame clear
- `clr_color` in DW: fill colour, sampled on an accepted `clr_start`
- `clr_busy` out 1: clear in progress
- `mem_addr` out 19, `mem_wdata` out DW, `mem_we` out 1: memory port
- `mem_rdata` in DW: memory read data (synchronous, 1-cycle latency)

## Operation
- Write slot = cycle with `disp_active`=0. Slot priority: clear engine, then FIFO head, then idle.
- `disp_active`=1: `mem_addr`=`disp_addr`, `mem_we`=0. No write is issued in that cycle.
- FIFO: push when `host_valid && host_ready`. `host_ready` = count < FIFO_DEPTH and depends only on registered count. Pop when the FIFO owns the write slot. Push and pop in the same cycle leave count unchanged.
- FSM states:
  - IDLE → CLEAR on `clr_start`. The colour is latched, x=0, y=0.
  - CLEAR: each write slot writes `clr_color` at {x,y}. y increments first. At y=V_PIX-1, y wraps to 0 and x increments. The write at (H_PIX-1, V_PIX-1) returns the FSM to IDLE.
- While CLEAR, the FIFO accepts until full but is not drained. Host writes therefore land after the clear and overwrite it.
- `clr_start` while `clr_busy`=1 is ignored.
- No address range check on host writes. Addresses are passed through as given.

## Timing
- Reset values: `host_ready`=1, `clr_busy`=0, `mem_we`=0, FIFO empty, FSM IDLE, x=y=0.
- `mem_addr`, `mem_wdata` and `mem_we` are combinational from `disp_active`, `disp_addr`, the FIFO head and FSM registers. There are no extra pipeline stages.
- Display read latency is 1 cycle: `disp_data` in cycle n+1 is the word at `disp_addr` of cycle n.
- Host write latency: the write reaches memory in the first write slot at least 1 cycle after the push, provided the FIFO is empty and the FSM is IDLE.
- `clr_busy` rises the cycle after `clr_start` and falls the cycle after the last clear write.
- A clear takes H_PIX*V_PIX write slots (307200), spread over blanking only.
- `rst` mid-clear or mid-drain: immediate abort. FIFO contents are discarded, and memory holds whatever was already written.

## Structure
- Shared package (`vga_pkg`):
  - H_PIX and V_PIX
  - Pixel width
  - The 19-bit address packing
  - FSM state enum {IDLE, CLEAR}
- Sub-module `sync_fifo` (parameterised depth and width, push/pop/count/full/empty), reusable elsewhere in the design.
- The arbiter itself contains the FSM, the x/y counters and the port mux.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `host_ready`=1, `clr_busy`=0, `mem_we`=0 immediately.
- Display priority: `disp_active`=1 with 4 queued writes → `mem_we` stays 0. `disp_active` falls → 4 consecutive writes in push order. `disp_data` follows `mem_rdata` for `disp_addr`=19'h1234 one cycle later.
- FIFO full: push 5 writes during active video → the 5th is not accepted (`host_ready`=0 after the 4th). First blanking cycle → pop, and `host_ready`=1 the next cycle.
- Clear with small parameters (H_PIX=4, V_PIX=3): `clr_start` with `clr_color`=12'hF00 → 12 writes in y-then-x order, {0,0},{0,1},{0,2},{1,0}…{3,2}. `clr_busy` drops after the last write.
- Clear vs host: a host write at {1,1}=12'h0F0 pushed during the clear → written after the clear completes, and the final memory value is 12'h0F0.
- Reset mid-clear: `rst` after 5 clear writes → `clr_busy`=0, no further `mem_we`. A second `clr_start` restarts at {0,0}.
